req_encoder: RTL and testbench



---
 rtl/req_encoder.sv | 94 +++++++++
 tb/tb_req_encoder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/req_encoder.sv
// Registered priority encoder: captures request lines into a pending register and
// presents the lowest-numbered pending line as a binary index under VALID/ACK.
module req_encoder #(
    parameter int WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  EN,
    input  logic [(1<<WIDTH)-1:0] REQ,
    input  logic                  ACK,
    output logic [WIDTH-1:0]      Y,
    output logic                  VALID,
    output logic [(1<<WIDTH)-1:0] PEND
);

    localparam int N = 1 << WIDTH;

    typedef enum logic {IDLE, SERVE} state_t;

    state_t             state_reg, state_next;
    logic [N-1:0]       pend_reg, pend_next;
    logic [WIDTH-1:0]   y_reg, y_next;
    logic               fire;
    logic [N-1:0]       clr;
    logic [N-1:0]       sel;
    logic               sel_any;
    logic [WIDTH-1:0]   enc;

    assign fire = (state_reg == SERVE) && ACK;

    // Decode the presented index so the served bit can be removed on handshake.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_clr
            assign clr[gi] = fire && (y_reg == WIDTH'(gi));
        end
    endgenerate

    // The acked bit is excluded here so it cannot be granted twice.
    assign sel       = pend_reg & ~clr;
    assign sel_any   = |sel;
    assign pend_next = sel | REQ;

    // Scan high to low so the lowest set bit is the one left standing.
    always_comb begin
        enc = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (sel[i]) begin
                enc = i[WIDTH-1:0];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        y_next     = y_reg;
        case (state_reg)
            IDLE: begin
                if (EN && sel_any) begin
                    state_next = SERVE;
                    y_next     = enc;
                end
            end
            SERVE: begin
                if (ACK) begin
                    if (EN && sel_any) begin
                        state_next = SERVE;
                        y_next     = enc;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            pend_reg  <= '0;
            y_reg     <= '0;
        end else begin
            state_reg <= state_next;
            pend_reg  <= pend_next;
            y_reg     <= y_next;
        end
    end

    assign Y     = y_reg;
    assign VALID = (state_reg == SERVE);
    assign PEND  = pend_reg;

endmodule

// File: tb/tb_req_encoder.sv
// Scoreboard bench for req_encoder: stimulus queues expected grant indices, a monitor
// pops and compares them on every handshake; state snapshots are checked directly.
module tb_req_encoder;

    localparam int WIDTH = 3;
    localparam int N     = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             reset;
    logic             EN;
    logic [N-1:0]     REQ;
    logic             ACK;
    logic [WIDTH-1:0] Y;
    logic             VALID;
    logic [N-1:0]     PEND;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    req_encoder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .EN    (EN),
        .REQ   (REQ),
        .ACK   (ACK),
        .Y     (Y),
        .VALID (VALID),
        .PEND  (PEND)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end else begin
            $display("ok   %s value=%0h", name, act);
        end
    endtask

    task automatic chk_state(input string name, input logic [N-1:0] p, input logic v);
        chk({name, ".pend"}, 32'(PEND), 32'(p));
        chk({name, ".valid"}, 32'(VALID), 32'(v));
    endtask

    // Monitor: every handshake must grant the next queued index.
    always @(negedge clk) begin
        if (!reset && VALID && ACK) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL grant unexpected actual=%0d expected=none", Y);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (32'(Y) !== e) begin
                    failures++;
                    $display("FAIL grant actual=%0d expected=%0d", Y, e);
                end else begin
                    $display("ok   grant y=%0d", Y);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        EN    = 1'b1;
        REQ   = 8'hFF;
        ACK   = 1'b0;

        // 1. Requests during reset are dropped
        step();
        chk_state("rst1", 8'h00, 1'b0);
        step();
        chk_state("rst2", 8'h00, 1'b0);
        chk("rst2.y", 32'(Y), 32'd0);
        reset = 1'b0;
        REQ   = 8'h00;
        step();
        chk_state("post_rst1", 8'h00, 1'b0);
        step();
        chk_state("post_rst2", 8'h00, 1'b0);
        chk("post_rst2.y", 32'(Y), 32'd0);

        // 2. Single request, two cycles to VALID
        REQ = 8'h20;
        step();
        REQ = 8'h00;
        chk_state("single.cap", 8'h20, 1'b0);
        step();
        chk_state("single.valid", 8'h20, 1'b1);
        chk("single.y", 32'(Y), 32'd5);
        exp_q.push_back(5);
        ACK = 1'b1;
        step();
        ACK = 1'b0;
        chk_state("single.done", 8'h00, 1'b0);

        // 3. Priority drain under continuous ACK
        REQ = 8'h91;
        step();
        REQ = 8'h00;
        chk_state("drain.cap", 8'h91, 1'b0);
        exp_q.push_back(0);
        exp_q.push_back(4);
        exp_q.push_back(7);
        ACK = 1'b1;
        step();
        chk_state("drain.g0", 8'h91, 1'b1);
        step();
        chk_state("drain.g4", 8'h90, 1'b1);
        step();
        chk_state("drain.g7", 8'h80, 1'b1);
        step();
        ACK = 1'b0;
        chk_state("drain.end", 8'h00, 1'b0);

        // 4. Higher-priority arrival does not pre-empt a presented index
        REQ = 8'h10;
        step();
        REQ = 8'h00;
        step();
        chk("hold.y0", 32'(Y), 32'd4);
        REQ = 8'h01;
        step();
        REQ = 8'h00;
        chk_state("hold.cap", 8'h11, 1'b1);
        chk("hold.y1", 32'(Y), 32'd4);
        step();
        chk("hold.y2", 32'(Y), 32'd4);
        exp_q.push_back(4);
        exp_q.push_back(0);
        ACK = 1'b1;
        step();
        chk_state("hold.next", 8'h01, 1'b1);
        chk("hold.y_next", 32'(Y), 32'd0);
        step();
        ACK = 1'b0;
        chk_state("hold.end", 8'h00, 1'b0);

        // 5. Set wins over clear on the same bit
        REQ = 8'h08;
        step();
        REQ = 8'h00;
        step();
        chk("setclr.y0", 32'(Y), 32'd3);
        exp_q.push_back(3);
        exp_q.push_back(3);
        ACK = 1'b1;
        REQ = 8'h08;
        step();
        REQ = 8'h00;
        chk_state("setclr.gap", 8'h08, 1'b0);
        step();
        chk_state("setclr.again", 8'h08, 1'b1);
        chk("setclr.y1", 32'(Y), 32'd3);
        step();
        ACK = 1'b0;
        chk_state("setclr.end", 8'h00, 1'b0);

        // 6. Enable gating, handshake with EN=0, mid-service reset
        EN  = 1'b0;
        REQ = 8'h06;
        step();
        REQ = 8'h00;
        chk_state("en0.cap", 8'h06, 1'b0);
        step();
        chk_state("en0.idle", 8'h06, 1'b0);
        EN = 1'b1;
        step();
        chk_state("en1.load", 8'h06, 1'b1);
        chk("en1.y", 32'(Y), 32'd1);
        exp_q.push_back(1);
        EN  = 1'b0;
        ACK = 1'b1;
        step();
        ACK = 1'b0;
        chk_state("en0.ack", 8'h04, 1'b0);
        EN = 1'b1;
        step();
        chk_state("en1.reload", 8'h04, 1'b1);
        chk("en1.y2", 32'(Y), 32'd2);
        reset = 1'b1;
        REQ   = 8'h01;
        ACK   = 1'b1;
        step();
        reset = 1'b0;
        REQ   = 8'h00;
        ACK   = 1'b0;
        chk_state("midrst", 8'h00, 1'b0);
        chk("midrst.y", 32'(Y), 32'd0);
        step();
        step();
        chk_state("final", 8'h00, 1'b0);
        chk("scoreboard.empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
